// File: rtl/alu_result_queue.sv
// ---------------------------------------------------------------------------
// alu_result_queue
//   First-word-fall-through result queue behind the 32-bit logic (AND) unit.
//   It captures every accepted unit result and holds up to DEPTH entries until
//   writeback consumes them. The head entry and its zero/negative flags are
//   always presented on the outputs. A sticky flag records any result that
//   was dropped because the queue was full.
//
// Ports
//   clk        i  clock; all state updates on the rising edge
//   rst_n      i  asynchronous active-low reset
//   in_valid   i  execute stage presents a result this cycle
//   in_data    i  result from the logic unit
//   in_ready   o  queue can accept (not full)
//   out_valid  o  head entry present (not empty)
//   out_data   o  head entry data
//   out_zero   o  head entry is zero
//   out_neg    o  head entry sign bit
//   out_ready  i  writeback consumes the head this cycle
//   count      o  number of entries held, 0..DEPTH
//   overflow   o  sticky: a push was attempted while full
//   clr_ovf    i  synchronous clear of overflow
// ---------------------------------------------------------------------------
module alu_result_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_zero,
    output logic                     out_neg,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_count;
    logic             r_ovf;

    logic w_push;
    logic w_pop;
    logic w_full;

    // Readiness comes from the registered count only, so a pop in the same
    // cycle never makes room for a push into a full queue.
    assign w_full   = (r_count == FULL);
    assign in_ready = ~w_full;
    assign out_valid = (r_count != '0);

    assign w_push = in_valid & ~w_full;
    assign w_pop  = out_ready & out_valid;

    // Storage is not reset; out_valid qualifies the head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            // A dropped push takes priority over a clear in the same cycle.
            if (in_valid && w_full) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign out_data = r_mem[r_rp];
    assign out_zero = (out_data == '0);
    assign out_neg  = out_data[WIDTH-1];
    assign count    = r_count;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_alu_result_queue.sv
module tb_alu_result_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_neg;
    logic             out_ready = 1'b0;
    logic [2:0]       count;
    logic             overflow;
    logic             clr_ovf = 1'b0;

    int passed = 0;
    int total  = 0;

    // Reference model: a plain queue of held results plus the sticky flag.
    logic [WIDTH-1:0] q[$];
    bit               m_ovf = 1'b0;

    alu_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_zero(out_zero),
        .out_neg(out_neg), .out_ready(out_ready), .count(count),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Compare every visible output against the model.
    task automatic check_all(input string tag);
        check({tag, ".count"}, 32'(count), 32'(q.size()));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() != DEPTH));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        if (q.size() != 0) begin
            check({tag, ".out_data"}, out_data, q[0]);
            check({tag, ".out_zero"}, 32'(out_zero), 32'(q[0] == 0));
            check({tag, ".out_neg"}, 32'(out_neg), 32'(q[0][WIDTH-1]));
        end
    endtask

    // Advance one clock: model absorbs the inputs present before the edge.
    task automatic step();
        bit push, pop;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] tmp;
        d    = in_data;
        push = in_valid && (q.size() != DEPTH);
        pop  = out_ready && (q.size() != 0);
        if (in_valid && q.size() == DEPTH) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        @(posedge clk);
        if (pop) tmp = q.pop_front();
        if (push) q.push_back(d);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    endtask

    initial begin
        int nv, ne;
        logic [WIDTH-1:0] r;

        // Reset state
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Ordered push of three values, then drain
        in_valid = 1'b1; in_data = 32'hFFFF0000; step();
        check("t1.first_fall_through", out_data, 32'hFFFF0000);
        in_data = 32'h00000000; step();
        in_data = 32'h80000001; step();
        idle();
        check("t1.count3", 32'(count), 32'd3);
        check_all("t1.held");
        out_ready = 1'b1;
        check("t1.head0_neg", 32'(out_neg), 32'd1);
        step();
        check("t1.head1_data", out_data, 32'h0);
        check("t1.head1_zero", 32'(out_zero), 32'd1);
        step();
        check("t1.head2_data", out_data, 32'h80000001);
        step();
        check_all("t1.drained");
        idle();

        // Fill, overflow attempt, drain, clear
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_data = $urandom; step();
        end
        check("t2.full_ready", 32'(in_ready), 32'd0);
        check("t2.full_count", 32'(count), 32'd4);
        in_data = 32'h12345678; step();
        check_all("t2.ovf");
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check_all("t2.drain"); step();
        end
        check_all("t2.empty");
        out_ready = 1'b0; clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        check("t2.ovf_cleared", 32'(overflow), 32'd0);

        // Full queue: push attempt and pop together
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_data = 32'(i + 100); step();
        end
        in_data = 32'hDEADBEEF; out_ready = 1'b1; step();
        check("t3.count", 32'(count), 32'd3);
        check("t3.ovf", 32'(overflow), 32'd1);
        check_all("t3");
        // Overflow set and clear in the same cycle: set wins
        in_valid = 1'b1; out_ready = 1'b0; in_data = 32'h1; step();
        in_data = 32'h2; clr_ovf = 1'b1; step();
        check("t6.set_wins", 32'(overflow), 32'd1);
        check_all("t6");
        idle(); clr_ovf = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) step();
        idle();
        check_all("t3.drained");

        // Streaming 1..20 with out_ready toggling
        nv = 1; ne = 1;
        for (int c = 0; c < 200 && ne <= 20; c++) begin
            in_valid  = (nv <= 20);
            in_data   = 32'(nv);
            out_ready = c[0];
            if (out_ready && q.size() != 0) begin
                check("t4.seq", out_data, 32'(ne));
                ne++;
            end
            if (in_valid && q.size() != DEPTH) nv++;
            step();
            check_all("t4");
        end
        check("t4.all_seen", 32'(ne), 32'd21);
        idle();

        // Asynchronous reset mid-operation with two entries held
        in_valid = 1'b1; in_data = 32'hA; step(); in_data = 32'hB; step(); idle();
        check("t5.pre_count", 32'(count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        q.delete(); m_ovf = 1'b0;
        check("t5.valid_drop", 32'(out_valid), 32'd0);
        check_all("t5.reset");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 32'hCAFE0001; step(); idle();
        check("t5.after_push", out_data, 32'hCAFE0001);
        check_all("t5.after");

        // Random traffic against the model
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: r = '0;
                1: r = 32'h80000000 | $urandom;
                default: r = $urandom;
            endcase
            in_data   = r;
            out_ready = ($urandom_range(0, 2) != 0);
            clr_ovf   = ($urandom_range(0, 15) == 0);
            step();
            check_all("rand");
        end
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
